// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, two byte-enabled
// write ports, pending-set request and pending count.
interface reg_file_sb_if #(
    parameter int DataWidth    = 32,
    parameter int Addres_depth = 5,
    parameter int NumRead      = 2
);
    logic [NumRead*Addres_depth-1:0] RA;
    logic [NumRead*DataWidth-1:0]    RD;
    logic [NumRead-1:0]              RDY;
    logic                            WE0;
    logic [Addres_depth-1:0]         WA0;
    logic [DataWidth-1:0]            WD0;
    logic [DataWidth/8-1:0]          BE0;
    logic                            WE1;
    logic [Addres_depth-1:0]         WA1;
    logic [DataWidth-1:0]            WD1;
    logic [DataWidth/8-1:0]          BE1;
    logic                            SET_EN;
    logic [Addres_depth-1:0]         SET_A;
    logic [Addres_depth:0]           PEND_CNT;

    modport master (
        output RA, WE0, WA0, WD0, BE0,
        output WE1, WA1, WD1, BE1,
        output SET_EN, SET_A,
        input  RD, RDY, PEND_CNT
    );

    modport slave (
        input  RA, WE0, WA0, WD0, BE0,
        input  WE1, WA1, WD1, BE1,
        input  SET_EN, SET_A,
        output RD, RDY, PEND_CNT
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with byte-enabled dual write, optional write
// bypass and a per-register pending scoreboard with a count.
module reg_file_sb #(
    parameter int DataWidth    = 32,
    parameter int Depth        = 32,
    parameter int Addres_depth = 5,
    parameter int NumRead      = 2,
    parameter int Forward      = 1
) (
    input  logic         clk,
    input  logic         RST,
    reg_file_sb_if.slave bus
);
    localparam int NB = DataWidth / 8;
    localparam int CW = Addres_depth + 1;

    logic [DataWidth-1:0]    r_mem [Depth];
    logic [Depth-1:0]        r_pend;
    logic [CW-1:0]           r_cnt;

    logic [Depth-1:0]        w_hit0;
    logic [Depth-1:0]        w_hit1;
    logic [Depth-1:0]        w_set;
    logic [Depth-1:0]        w_clr;
    logic                    w_inc;
    logic [1:0]              w_dec;
    int                      w_sum;
    logic [CW-1:0]           w_cnt_nxt;
    logic [Addres_depth-1:0] w_ra [NumRead];
    logic [DataWidth-1:0]    w_rd [NumRead];

    // Register 0 is excluded from every write and set decode
    always_comb begin
        w_hit0 = '0;
        w_hit1 = '0;
        w_set  = '0;
        for (int i = 1; i < Depth; i++) begin
            w_hit0[i] = bus.WE0 && (bus.WA0 == Addres_depth'(i));
            w_hit1[i] = bus.WE1 && (bus.WA1 == Addres_depth'(i));
            w_set[i]  = bus.SET_EN && (bus.SET_A == Addres_depth'(i));
        end
        w_clr = w_hit0 | w_hit1;
    end

    always_comb begin
        w_inc = |(w_set & ~r_pend);
        w_dec = '0;
        for (int i = 0; i < Depth; i++) begin
            if (w_clr[i] && r_pend[i] && !w_set[i]) begin
                w_dec = w_dec + 2'd1;
            end
        end
        w_sum = int'(r_cnt) + (w_inc ? 1 : 0) - int'(w_dec);
        if (w_sum > Depth - 1) begin
            w_sum = Depth - 1;
        end
        if (w_sum < 0) begin
            w_sum = 0;
        end
        w_cnt_nxt = CW'(w_sum);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 1; i < Depth; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_hit1[i] && bus.BE1[b]) begin
                        r_mem[i][b*8 +: 8] <= bus.WD1[b*8 +: 8];
                    end else if (w_hit0[i] && bus.BE0[b]) begin
                        r_mem[i][b*8 +: 8] <= bus.WD0[b*8 +: 8];
                    end
                end
            end
            r_pend <= w_set | (r_pend & ~w_clr);
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Bypass merges port 0 then port 1 bytes over the stored word
    always_comb begin
        bus.RD  = '0;
        bus.RDY = '0;
        for (int k = 0; k < NumRead; k++) begin
            w_ra[k] = bus.RA[k*Addres_depth +: Addres_depth];
            w_rd[k] = r_mem[w_ra[k]];
            if (Forward != 0 && !RST) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_hit1[w_ra[k]] && bus.BE1[b]) begin
                        w_rd[k][b*8 +: 8] = bus.WD1[b*8 +: 8];
                    end else if (w_hit0[w_ra[k]] && bus.BE0[b]) begin
                        w_rd[k][b*8 +: 8] = bus.WD0[b*8 +: 8];
                    end
                end
            end
            if (w_ra[k] == '0) begin
                w_rd[k] = '0;
            end
            bus.RD[k*DataWidth +: DataWidth] = w_rd[k];
            if (RST) begin
                bus.RDY[k] = 1'b1;
            end else if (Forward != 0) begin
                bus.RDY[k] = !r_pend[w_ra[k]] ||
                             (w_clr[w_ra[k]] && !w_set[w_ra[k]]);
            end else begin
                bus.RDY[k] = !r_pend[w_ra[k]];
            end
        end
    end

    assign bus.PEND_CNT = r_cnt;
endmodule
